// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump/call/return selection and a circular
// return-address stack that overwrites its oldest entry when full.
module pc_branch_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     IMM_SHIFT = 2,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jaddr_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_inc_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_ovf_o,
  output logic             ras_udf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] ras_q [DEPTH];
  logic             ras_we;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] br_target;
  logic             empty, full;

  assign pc_inc    = pc_q + WIDTH'(INC);
  // Immediate is already sign-extended, so a plain shift keeps two's complement.
  assign br_target = pc_inc + (imm_i << IMM_SHIFT);
  assign rd_ptr    = wp_q - 1'b1;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));

  always_comb begin
    pc_d   = pc_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    ras_we = 1'b0;
    if (!stall_i) begin
      if (ret_i) begin
        if (empty) begin
          pc_d  = pc_inc;
          udf_d = 1'b1;
        end else begin
          pc_d  = ras_q[rd_ptr];
          wp_d  = rd_ptr;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (call_i) begin
        pc_d   = jaddr_i;
        ras_we = 1'b1;
        wp_d   = wp_q + 1'b1;
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + 1'b1;
      end else if (jump_i) begin
        pc_d = jaddr_i;
      end else if (branch_i) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q  <= RESET_VEC;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Entries are cleared on reset so stale return addresses never survive.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ras
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          ras_q[gi] <= '0;
        end else if (ras_we && (wp_q == PW'(gi))) begin
          ras_q[gi] <= pc_inc;
        end
      end
    end
  endgenerate

  assign pc_o        = pc_q;
  assign pc_inc_o    = pc_inc;
  assign ras_empty_o = empty;
  assign ras_full_o  = full;
  assign ras_ovf_o   = ovf_q;
  assign ras_udf_o   = udf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: sequencing, branches, calls/returns,
// RAS overflow/underflow, stall and asynchronous reset.
module tb_pc_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, jump, call, ret;
  logic [31:0] imm, jaddr;
  logic [31:0] pc, pc_inc;
  logic        ras_empty, ras_full, ras_ovf, ras_udf;

  int n_cmp = 0;
  int n_err = 0;

  pc_branch_unit #(
    .WIDTH(32), .INC(4), .IMM_SHIFT(2), .DEPTH(4), .RESET_VEC(32'h0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .branch_i(branch),
    .imm_i(imm), .jump_i(jump), .jaddr_i(jaddr), .call_i(call), .ret_i(ret),
    .pc_o(pc), .pc_inc_o(pc_inc), .ras_empty_o(ras_empty), .ras_full_o(ras_full),
    .ras_ovf_o(ras_ovf), .ras_udf_o(ras_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; branch = 0; jump = 0; call = 0; ret = 0; imm = '0; jaddr = '0;
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    #1;
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    n_cmp++;
    if (pc !== exp) begin
      n_err++;
      $display("FAIL %s: pc=%h expected %h", name, pc, exp);
    end else $display("ok   %s: pc=%h", name, pc);
  endtask

  task automatic check_flags(input string name, input logic e, input logic f,
                             input logic o, input logic u);
    n_cmp++;
    if ({ras_empty, ras_full, ras_ovf, ras_udf} !== {e, f, o, u}) begin
      n_err++;
      $display("FAIL %s: empty/full/ovf/udf=%b%b%b%b expected %b%b%b%b", name,
               ras_empty, ras_full, ras_ovf, ras_udf, e, f, o, u);
    end else $display("ok   %s: flags=%b%b%b%b", name, ras_empty, ras_full, ras_ovf, ras_udf);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    check_pc("reset_pc", 32'h0);
    check_flags("reset_flags", 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    step(); check_pc("seq1", 32'h4);
    step(); check_pc("seq2", 32'h8);
    n_cmp++;
    if (pc_inc !== 32'hC) begin
      n_err++;
      $display("FAIL seq_pc_inc: pc_inc=%h expected %h", pc_inc, 32'hC);
    end else $display("ok   seq_pc_inc: pc_inc=%h", pc_inc);
    step(); check_pc("seq3", 32'hC);
    check_flags("seq_flags", 1, 0, 0, 0);
  endtask

  task automatic test_branch();
    do_reset();
    step(); step();
    check_pc("br_start", 32'h8);
    branch = 1; imm = 32'hFFFF_FFFE;
    step(); check_pc("br_back", 32'h4);
    imm = 32'h0000_0003;
    step(); check_pc("br_fwd", 32'h14);
    idle();
    jump = 1; jaddr = 32'hFFFF_FFFC;
    step(); check_pc("jump_top", 32'hFFFF_FFFC);
    idle();
    n_cmp++;
    if (pc_inc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc_inc: pc_inc=%h expected %h", pc_inc, 32'h0);
    end else $display("ok   wrap_pc_inc: pc_inc=%h", pc_inc);
    step(); check_pc("wrap_seq", 32'h0);
  endtask

  task automatic test_call_ret();
    do_reset();
    jump = 1; jaddr = 32'h10;
    step(); check_pc("cr_jump", 32'h10);
    idle(); call = 1; jaddr = 32'h100;
    step(); check_pc("cr_call", 32'h100);
    check_flags("cr_count1", 0, 0, 0, 0);
    idle(); ret = 1;
    step(); check_pc("cr_ret", 32'h14);
    check_flags("cr_empty", 1, 0, 0, 0);
    idle();
  endtask

  task automatic test_nested();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      call = 1; jaddr = 32'(i) << 8;
      step();
      check_pc($sformatf("nest_call%0d", i), 32'(i) << 8);
      check_flags($sformatf("nest_flags%0d", i), 0, (i == 4), 0, 0);
    end
    jaddr = 32'h500;
    step(); check_pc("nest_call5", 32'h500);
    check_flags("nest_ovf", 0, 1, 1, 0);
    idle(); ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_pc($sformatf("nest_ret%0d", i + 1), exp_ret[i]);
      check_flags($sformatf("nest_rflags%0d", i + 1), (i == 3), 0, 0, 0);
    end
    step(); check_pc("nest_ret5", 32'h108);
    check_flags("nest_udf", 1, 0, 0, 1);
    idle();
    step(); check_flags("nest_udf_clear", 1, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    call = 1; jaddr = 32'h100;
    step(); check_pc("st_call", 32'h100);
    idle();
    stall = 1; ret = 1; branch = 1; imm = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pc($sformatf("st_hold%0d", i), 32'h100);
      check_flags($sformatf("st_flags%0d", i), 0, 0, 0, 0);
    end
    stall = 0;
    step(); check_pc("st_release_ret", 32'h4);
    check_flags("st_release_flags", 1, 0, 0, 0);
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    call = 1; ret = 1; jaddr = 32'h200;
    step(); check_pc("prio_ret_over_call", 32'h4);
    check_flags("prio_ret_only", 1, 0, 0, 1);
    idle();
    jump = 1; branch = 1; jaddr = 32'h300; imm = 32'h1;
    step(); check_pc("prio_jump_over_branch", 32'h300);
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    call = 1;
    for (int i = 1; i <= 3; i++) begin
      jaddr = 32'(i) << 8;
      step();
    end
    check_pc("ar_pre", 32'h300);
    ret = 1;
    #2;
    rst_n = 0;
    #1;
    check_pc("ar_pc", 32'h0);
    check_flags("ar_flags", 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    call = 0;
    step(); check_pc("ar_first_edge", 32'h4);
    check_flags("ar_discarded", 1, 0, 0, 1);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_branch();
    test_call_ret();
    test_nested();
    test_stall();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter WIDTH, default 32: width of PC, immediate and jump address.
REQ-002 Parameter INC, default 4: sequential PC increment.
REQ-003 Parameter IMM_SHIFT, default 2: left shift applied to the branch immediate.
REQ-004 Parameter DEPTH, default 4: return-address-stack (RAS) entries; power of two, at least 2.
REQ-005 Parameter RESET_VEC, default 0: PC value after reset.
REQ-006 Clk  in  1  clock; all state changes on rising edge.
REQ-007 Rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Stall  in  1  hold PC and RAS.
REQ-009 Branch  in  1  conditional branch taken.
REQ-010 Imm  in  WIDTH  sign-extended branch offset, word units.
REQ-011 Jump  in  1  absolute jump.
REQ-012 JAddr  in  WIDTH  absolute target for Jump and Call.
REQ-013 Call  in  1  jump to JAddr and push return address.
REQ-014 Ret  in  1  return to the address popped from the RAS.
REQ-015 PC  out  WIDTH  registered program counter.
REQ-016 PC_inc  out  WIDTH  combinational PC+INC.
REQ-017 Ras_empty, Ras_full  out  1 each  RAS occupancy flags.
REQ-018 Ras_ovf, Ras_udf  out  1 each  registered one-cycle error pulses.

Function
REQ-019 All PC arithmetic SHALL be modulo 2^WIDTH; carries out of bit WIDTH-1 are discarded and wrap-around is silent.
REQ-020 Branch target SHALL be PC_inc + (Imm << IMM_SHIFT), where Imm is treated as two's complement.
REQ-021 Next PC SHALL be selected per cycle by fixed priority: Stall (hold) > Ret > Call > Jump > Branch > sequential (PC_inc).
REQ-022 Latency SHALL be one cycle: the control inputs sampled at edge N determine the PC visible after edge N.
REQ-023 RAS SHALL be a circular buffer with a write pointer and a count in the range 0..DEPTH.
REQ-024 Call SHALL write PC_inc at the write pointer, advance the pointer modulo DEPTH, and increment the count saturating at DEPTH.
REQ-025 Call when full SHALL overwrite the oldest entry, leave the count at DEPTH, and pulse Ras_ovf for one cycle.
REQ-026 Ret when not empty SHALL load PC from the entry at pointer-1, decrement the pointer modulo DEPTH, and decrement the count.
REQ-027 Ret when empty SHALL load PC_inc, leave the RAS unchanged, and pulse Ras_udf for one cycle.
REQ-028 Because of the priority order, Call and Ret SHALL never both act on the RAS in the same cycle; when both are asserted, only Ret acts.
REQ-029 Stall SHALL suppress every PC and RAS update and force Ras_ovf and Ras_udf to 0 for that cycle.
REQ-030 Ras_empty SHALL equal (count==0) and Ras_full SHALL equal (count==DEPTH), both derived from registered state.

Reset
REQ-031 Rst_n low SHALL immediately, without waiting for a clock edge, set: PC=RESET_VEC; pointer=0; count=0; all RAS entries=0; Ras_ovf=0; Ras_udf=0.
REQ-032 While Rst_n is low, all inputs SHALL be ignored.
REQ-033 After Rst_n deasserts, the first rising edge SHALL perform a normal update.
REQ-034 Reset asserted mid-operation SHALL discard the RAS contents.

Verification
REQ-035 Release reset with no control inputs, 3 edges -> PC=0x0, 0x4, 0x8, 0xC; Ras_empty=1.
REQ-036 At PC=0x8, Branch=1 with Imm=0xFFFFFFFE -> next PC=0x4; at PC=0xFFFFFFFC sequential -> PC=0x0.
REQ-037 At PC=0x10, Call with JAddr=0x100 -> PC=0x100 and count=1; then Ret -> PC=0x14 and Ras_empty=1.
REQ-038 Five nested Calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 (DEPTH=4) -> Ras_ovf pulses only on the 5th Call; four Rets -> PCs 0x404, 0x304, 0x204, 0x104; 5th Ret -> Ras_udf pulse and PC=PC_inc.
REQ-039 Stall=1 held together with Ret and Branch for 3 edges -> PC, count and flags unchanged; dropping Stall -> Ret executes.
REQ-040 Rst_n pulsed low between edges with count=3 -> PC=RESET_VEC and Ras_empty=1 before the next edge.
